// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: turns 32-bit instruction fetches and 1/2/4-byte
// loads/stores into a sequence of single-byte accesses on an 8-bit RAM port.
module mem_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  input  logic        flush,
  output logic        inst_done,
  output logic [31:0] inst_o,
  output logic [31:0] inst_pc,
  input  logic        data_req,
  input  logic        data_we,
  input  logic [31:0] data_addr,
  input  logic [1:0]  data_len,
  input  logic [31:0] data_wdata,
  output logic        data_done,
  output logic [31:0] data_rdata,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  output logic [1:0]  dbg_state
);

  // Handshake: a requester holds *_req (and its operands) until it sees the
  // matching one-cycle *_done; requests are only sampled while the FSM is IDLE,
  // and a request still present in the done cycle is granted at that cycle's end.
  typedef enum logic [1:0] {IDLE = 2'd0, INST = 2'd1, DREAD = 2'd2, DWRITE = 2'd3} state_t;

  state_t      state, state_nx;
  logic [2:0]  cnt, cnt_inc, n, len_n;
  logic [31:0] base, wdata, rbuf, rd_word, wshift;
  logic [31:0] mem_a_nx;
  logic [7:0]  mem_dout_nx;
  logic        mem_wr_nx, inst_done_nx, data_done_nx;

  assign cnt_inc   = cnt + 3'd1;
  assign len_n     = (data_len == 2'b00) ? 3'd1 : (data_len == 2'b01) ? 3'd2 : 3'd4;
  assign rd_word   = rbuf | ({24'b0, mem_din} << {cnt - 3'd1, 3'b000});
  assign wshift    = wdata >> {cnt_inc, 3'b000};
  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (data_req)                state_nx = data_we ? DWRITE : DREAD;
        else if (inst_req && !flush) state_nx = INST;
      end
      INST:    if (flush || cnt == n) state_nx = IDLE;
      DREAD:   if (cnt == n)          state_nx = IDLE;
      DWRITE:  if (cnt_inc == n)      state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Next values for the registered RAM port and done pulses.
  always_comb begin
    mem_a_nx     = '0;
    mem_dout_nx  = '0;
    mem_wr_nx    = 1'b0;
    inst_done_nx = 1'b0;
    data_done_nx = 1'b0;
    case (state)
      IDLE: begin
        if (data_req) begin
          mem_a_nx = data_addr;
          if (data_we) begin
            mem_wr_nx   = 1'b1;
            mem_dout_nx = data_wdata[7:0];
          end
        end else if (inst_req && !flush) begin
          mem_a_nx = inst_addr;
        end
      end
      INST, DREAD: begin
        if (state_nx == state && cnt_inc < n) mem_a_nx = base + {29'b0, cnt_inc};
        if (cnt == n) begin
          if (state == INST) inst_done_nx = !flush;
          else               data_done_nx = 1'b1;
        end
      end
      DWRITE: begin
        if (cnt_inc < n) begin
          mem_wr_nx   = 1'b1;
          mem_a_nx    = base + {29'b0, cnt_inc};
          mem_dout_nx = wshift[7:0];
        end else begin
          data_done_nx = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt        <= '0;
      n          <= '0;
      base       <= '0;
      wdata      <= '0;
      rbuf       <= '0;
      mem_a      <= '0;
      mem_dout   <= '0;
      mem_wr     <= 1'b0;
      inst_done  <= 1'b0;
      data_done  <= 1'b0;
      inst_o     <= '0;
      inst_pc    <= '0;
      data_rdata <= '0;
    end else begin
      mem_a     <= mem_a_nx;
      mem_dout  <= mem_dout_nx;
      mem_wr    <= mem_wr_nx;
      inst_done <= inst_done_nx;
      data_done <= data_done_nx;
      if (state == IDLE) begin
        cnt <= '0;
        if (data_req) begin
          base  <= data_addr;
          wdata <= data_wdata;
          n     <= len_n;
          rbuf  <= '0;
        end else if (inst_req && !flush) begin
          base <= inst_addr;
          n    <= 3'd4;
          rbuf <= '0;
        end
      end else begin
        cnt <= cnt_inc;
      end
      // Byte cnt-1 arrives on mem_din one cycle after its address was driven.
      if ((state == INST || state == DREAD) && cnt != 3'd0) rbuf <= rd_word;
      if (inst_done_nx) begin
        inst_o  <= rd_word;
        inst_pc <= base;
      end
      if (data_done_nx && state == DREAD) data_rdata <= rd_word;
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: byte RAM environment, reference byte-array model, directed
// corner cases plus randomized fetch/load/store traffic.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        inst_req = 1'b0, flush = 1'b0, data_req = 1'b0, data_we = 1'b0;
  logic [31:0] inst_addr = '0, data_addr = '0, data_wdata = '0;
  logic [1:0]  data_len = '0;
  logic        inst_done, data_done, mem_wr;
  logic [31:0] inst_o, inst_pc, data_rdata, mem_a;
  logic [7:0]  mem_din = '0, mem_dout;
  logic [1:0]  dbg_state;

  int total = 0;
  int bad = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_rdata = '0;

  logic [7:0] ram[logic [31:0]];
  logic [7:0] ref_mem[logic [31:0]];

  mem_ctrl dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr), .flush(flush),
    .inst_done(inst_done), .inst_o(inst_o), .inst_pc(inst_pc),
    .data_req(data_req), .data_we(data_we), .data_addr(data_addr),
    .data_len(data_len), .data_wdata(data_wdata),
    .data_done(data_done), .data_rdata(data_rdata),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  function automatic logic [7:0] init_byte(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ a[31:24] ^ 8'h5A;
  endfunction

  function automatic logic [7:0] ram_rd(input logic [31:0] a);
    return ram.exists(a) ? ram[a] : init_byte(a);
  endfunction

  function automatic logic [7:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_byte(a);
  endfunction

  // RAM environment with one cycle of read latency
  always @(posedge clk) begin
    if (mem_wr) ram[mem_a] = mem_dout;
    mem_din <= ram_rd(mem_a);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic poke(input logic [31:0] a, input logic [7:0] b);
    ram[a] = b;
    ref_mem[a] = b;
  endtask

  function automatic int len_bytes(input logic [1:0] len);
    return (len == 2'b00) ? 1 : (len == 2'b01) ? 2 : 4;
  endfunction

  // kind: 0 fetch, 1 load, 2 store. Called at a negedge with the DUT idle.
  task automatic run_xact(input int kind, input logic [31:0] addr,
                          input logic [1:0] len, input logic [31:0] wd);
    int n, lat;
    logic [31:0] exp_word;
    logic done_seen, dn, other;
    n = (kind == 0) ? 4 : len_bytes(len);
    lat = (kind == 2) ? n : n + 1;
    exp_word = '0;
    for (int t = 0; t < n; t++) begin
      if (kind == 2) ref_mem[addr + t] = wd[8*t +: 8];
      else exp_word = exp_word | ({24'b0, ref_rd(addr + t)} << (8 * t));
    end
    if (kind != 2) exp_q.push_back(exp_word);
    if (kind == 0) begin
      inst_req = 1'b1; inst_addr = addr;
    end else begin
      data_req = 1'b1; data_we = (kind == 2); data_addr = addr;
      data_len = len; data_wdata = wd;
    end
    done_seen = 1'b0;
    for (int cyc = 0; cyc <= lat + 3 && !done_seen; cyc++) begin
      @(negedge clk);
      dn    = (kind == 0) ? inst_done : data_done;
      other = (kind == 0) ? data_done : inst_done;
      if (cyc < n) begin
        check("bus_addr", mem_a, addr + cyc);
        check("bus_wr", {31'b0, mem_wr}, {31'b0, kind == 2});
        if (kind == 2) check("bus_dout", {24'b0, mem_dout}, {24'b0, wd[8*cyc +: 8]});
      end
      if (dn) begin
        done_seen = 1'b1;
        check("done_cycle", cyc, lat);
        check("done_excl", {31'b0, other}, 32'd0);
        check("done_idle", {30'b0, dbg_state}, 32'd0);
        check("done_nowr", {31'b0, mem_wr}, 32'd0);
        if (kind == 0) begin
          check("inst_o", inst_o, exp_q.pop_front());
          check("inst_pc", inst_pc, addr);
          check("rdata_hold", data_rdata, last_rdata);
          inst_req = 1'b0;
        end else begin
          if (kind == 1) begin
            last_rdata = exp_q.pop_front();
            check("data_rdata", data_rdata, last_rdata);
          end else begin
            check("rdata_hold_st", data_rdata, last_rdata);
          end
          data_req = 1'b0;
        end
      end
    end
    if (!done_seen) begin
      check("done_timeout", 32'd0, 32'd1);
      inst_req = 1'b0; data_req = 1'b0;
      if (kind != 2) void'(exp_q.pop_front());
    end
  endtask

  initial begin
    logic [31:0] w, a;
    logic done_d, done_i;
    // reset state
    #3;
    check("rst_mem_a", mem_a, 32'd0);
    check("rst_mem_wr", {31'b0, mem_wr}, 32'd0);
    check("rst_dones", {30'b0, inst_done, data_done}, 32'd0);
    check("rst_state", {30'b0, dbg_state}, 32'd0);
    @(negedge clk); rst = 1'b1;

    // fetch of 0x00000513 at 0x100
    poke(32'h100, 8'h13); poke(32'h101, 8'h05); poke(32'h102, 8'h00); poke(32'h103, 8'h00);
    run_xact(0, 32'h100, 2'b10, '0);
    check("fetch_word", inst_o, 32'h0000_0513);

    // store word then read it back, half load across the address wrap
    run_xact(2, 32'h30, 2'b11, 32'h1122_3344);
    run_xact(1, 32'h30, 2'b11, '0);
    run_xact(1, 32'hFFFF_FFFF, 2'b01, '0);
    run_xact(1, 32'h31, 2'b10, '0);

    // simultaneous data byte load and fetch: data first, fetch back-to-back
    poke(32'h20, 8'hAB);
    w = {ref_rd(32'h3), ref_rd(32'h2), ref_rd(32'h1), ref_rd(32'h0)};
    inst_req = 1'b1; inst_addr = 32'h0;
    data_req = 1'b1; data_we = 1'b0; data_addr = 32'h20; data_len = 2'b00;
    done_d = 1'b0; done_i = 1'b0;
    for (int cyc = 0; cyc < 14 && !done_i; cyc++) begin
      @(negedge clk);
      if (data_done) begin
        done_d = 1'b1;
        check("sim_d_cycle", cyc, 2);
        check("sim_d_rdata", data_rdata, 32'h0000_00AB);
        check("sim_d_excl", {31'b0, inst_done}, 32'd0);
        last_rdata = 32'h0000_00AB;
        data_req = 1'b0;
      end
      if (inst_done) begin
        done_i = 1'b1;
        check("sim_i_cycle", cyc, 8);
        check("sim_i_word", inst_o, w);
        check("sim_i_pc", inst_pc, 32'h0);
        inst_req = 1'b0;
      end
    end
    check("sim_both_done", {30'b0, done_d, done_i}, 32'd3);
    inst_req = 1'b0; data_req = 1'b0;

    // flush in c2 of a fetch
    inst_req = 1'b1; inst_addr = 32'h200;
    repeat (3) begin
      @(negedge clk);
      check("fl_no_done", {31'b0, inst_done}, 32'd0);
    end
    flush = 1'b1;
    @(negedge clk);
    check("fl_mem_a", mem_a, 32'd0);
    check("fl_idle", {30'b0, dbg_state}, 32'd0);
    flush = 1'b0; inst_req = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("fl_no_done", {31'b0, inst_done}, 32'd0);
    end
    run_xact(0, 32'h200, 2'b00, '0);

    // reset after two bytes of a word store
    w = 32'hCAFE_F00D;
    data_req = 1'b1; data_we = 1'b1; data_addr = 32'h40; data_len = 2'b11; data_wdata = w;
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("ar_mem_wr", {31'b0, mem_wr}, 32'd0);
    check("ar_mem_a", mem_a, 32'd0);
    check("ar_dout", {24'b0, mem_dout}, 32'd0);
    check("ar_outs", inst_o | inst_pc | data_rdata, 32'd0);
    check("ar_state", {30'b0, dbg_state, data_done, inst_done}, 32'd0);
    ref_mem[32'h40] = w[7:0];
    ref_mem[32'h41] = w[15:8];
    last_rdata = '0;
    data_req = 1'b0;
    @(negedge clk); rst = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("ar_no_done", {31'b0, data_done}, 32'd0);
    end
    run_xact(1, 32'h40, 2'b11, '0);

    // randomized traffic
    for (int i = 0; i < 40; i++) begin
      a = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFFF - $urandom_range(0, 3)) : {24'b0, 8'($urandom_range(0, 255))};
      run_xact($urandom_range(0, 2), a, 2'($urandom_range(0, 3)), $urandom);
      if ($urandom_range(0, 2) == 0) @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 Parameters: none; RAM port is 8-bit data, 32-bit address.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 inst_req  input  1  instruction fetch request; held until inst_done or flush.
REQ-005 inst_addr  input  32  fetch address.
REQ-006 flush  input  1  abort in-flight or pending instruction fetch.
REQ-007 inst_done  output  1  one-cycle pulse; inst_o and inst_pc valid.
REQ-008 inst_o  output  32  fetched instruction word.
REQ-009 inst_pc  output  32  address of inst_o.
REQ-010 data_req  input  1  load/store request; held until data_done.
REQ-011 data_we  input  1  1 = store, 0 = load.
REQ-012 data_addr  input  32  data byte address; no alignment check.
REQ-013 data_len  input  2  00 byte, 01 half, 11 word; 10 treated as word.
REQ-014 data_wdata  input  32  store data, little-endian.
REQ-015 data_done  output  1  one-cycle pulse; transfer complete.
REQ-016 data_rdata  output  32  load data, zero-extended above the transferred length.
REQ-017 mem_din  input  8  RAM read data, returned the cycle after the address is driven on mem_a.
REQ-018 mem_dout  output  8  RAM write data.
REQ-019 mem_a  output  32  RAM byte address.
REQ-020 mem_wr  output  1  1 = write mem_dout to mem_a this cycle.

Function
REQ-021 FSM states are IDLE, INST, DREAD, DWRITE, with a 3-bit byte counter and latched base address, length and write data.
REQ-022 Requests are sampled only in IDLE; request inputs in other states are ignored.
REQ-023 Arbitration in IDLE: data_req wins; else inst_req && !flush -> INST; data has fixed priority.
REQ-024 mem_a, mem_dout and mem_wr are registered; in IDLE they are 0.
REQ-025 N = 1/2/4 bytes from data_len; inst fetch always has N = 4.
REQ-026 Byte t uses address base+t (32-bit wrap) and bits [8t+7:8t].
REQ-027 Reads: mem_a = base+t in cycles c0..c(N-1) after the grant edge; byte t is captured from mem_din at the end of cycle c(t+1).
REQ-028 Read completion: done pulses in cycle c(N+1) with data valid, and the FSM is IDLE in that cycle.
REQ-029 Writes: mem_wr=1, mem_a=base+t, mem_dout=byte t in cycles c0..c(N-1); data_done pulses in cycle cN with mem_wr=0, and the FSM is IDLE in that cycle.
REQ-030 inst_o/inst_pc and data_rdata hold their last completed value until the next completion of the same type.
REQ-031 Back-to-back: a request present in the done cycle is granted at that cycle's ending edge.
REQ-032 flush in INST: return to IDLE at the next edge; no inst_done; mem_a becomes 0. flush never affects DREAD/DWRITE.
REQ-033 Simultaneous data_req and inst_req: data is served first; inst is granted afterwards if inst_req is still high.
REQ-034 inst_done and data_done are never high in the same cycle.

Reset
REQ-035 rst low immediately forces IDLE, counter 0, and all outputs 0, including mem_wr.
REQ-036 Reset mid-transfer aborts the transfer without a done pulse; partial writes already issued are not undone.
REQ-037 The first grant can occur at the first rising edge after rst rises.

Verification
REQ-038 Fetch at 0x100 with RAM bytes 13,05,00,00 -> inst_done in c5, inst_o=0x00000513, inst_pc=0x100.
REQ-039 Simultaneous inst_req@0x0 and data load byte@0x20 (0xAB) -> data_done in c2 with data_rdata=0x000000AB; inst granted at the end of c2, and inst_done follows 5 cycles after that grant.
REQ-040 Store word 0x11223344@0x30 -> mem_wr=1 in c0..c3 with mem_a 0x30..0x33 and mem_dout 44,33,22,11; data_done in c4 with mem_wr=0.
REQ-041 flush asserted in c2 of a fetch -> no inst_done, mem_a=0 in the next cycle; the next fetch completes normally.
REQ-042 rst low after 2 bytes of a word store -> mem_wr=0 asynchronously, all outputs 0, no data_done.
REQ-043 Half load at 0xFFFFFFFF -> mem_a 0xFFFFFFFF then 0x00000000; data_rdata = {16'h0, byte1, byte0}.
